// File: rtl/icache_controller_pkg.sv
// -----------------------------------------------------------------------------
// icache_controller_pkg
// Shared geometry, types and helpers for the direct-mapped instruction cache.
// Address layout (byte address): { tag | index | word select | byte (2 bits) }.
// No ports (package).
// -----------------------------------------------------------------------------
package icache_controller_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INST_WIDTH  = 32;
    localparam int BLOCKS      = 4;    // instructions per line, power of 2
    localparam int SETS        = 16;   // lines in the cache, power of 2

    localparam int WORD_BITS   = $clog2(BLOCKS);
    localparam int OFFSET_BITS = $clog2(BLOCKS * 4);
    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [INDEX_BITS-1:0] index_t;
    typedef logic [WORD_BITS-1:0]  word_sel_t;
    typedef logic [INST_WIDTH-1:0] inst_t;
    typedef inst_t [BLOCKS-1:0]    line_t;

    localparam word_sel_t LAST_WORD = word_sel_t'(BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        UPDATE
    } state_t;

    // Word-aligned memory address of one word inside a line.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(tag_t tag, index_t index, word_sel_t sel);
        return {tag, index, sel, 2'b00};
    endfunction

endpackage

// File: rtl/icache_controller_if.sv
// -----------------------------------------------------------------------------
// icache_controller_if
// Fetch-side bus between the IF stage (master) and the instruction cache
// (slave).
//   addr : byte address of the requested instruction (master -> slave)
//   re   : read request                              (master -> slave)
//   inst : whole line containing addr                (slave -> master)
//   busy : request not served this cycle             (slave -> master)
// -----------------------------------------------------------------------------
interface icache_controller_if;
    import icache_controller_pkg::*;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  re;
    line_t                 inst;
    logic                  busy;

    modport master (output addr, output re, input inst, input busy);
    modport slave  (input addr, input re, output inst, output busy);

endinterface

// File: rtl/icache_controller_storage.sv
// -----------------------------------------------------------------------------
// icache_controller_storage
// Tag, valid and data arrays of the cache.
//   clk, rst_n   : clock, asynchronous active-low reset (clears valid bits only)
//   rd_index     : combinational read port index
//   rd_valid/rd_tag/rd_line : contents of line rd_index
//   wr_en        : write tag and data of line wr_index at the next edge
//   set_valid    : together with wr_en, mark line wr_index valid
//   inv_all      : clear every valid bit at the next edge (wins over set_valid)
// -----------------------------------------------------------------------------
module icache_controller_storage
    import icache_controller_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  index_t rd_index,
    output logic   rd_valid,
    output tag_t   rd_tag,
    output line_t  rd_line,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  line_t  wr_line,
    input  logic   set_valid,
    input  logic   inv_all
);

    logic [SETS-1:0] valid;
    tag_t            tag_mem  [SETS];
    line_t           data_mem [SETS];

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (wr_en && set_valid) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, which keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache_controller.sv
// -----------------------------------------------------------------------------
// icache_controller
// Direct-mapped instruction cache. Hits are served in the request cycle;
// a miss fills the line word by word from instruction memory, installs it in
// one extra cycle and then returns to lookup.
//   i_clock, i_reset : clock, asynchronous active-low reset
//   cacheBus         : fetch bus, slave side (addr/re in, inst/busy out)
//   o_mem_addr       : word-aligned memory read address
//   o_mem_re         : memory read request, held until i_mem_ack
//   i_mem_rdata      : memory read data, valid with i_mem_ack
//   i_mem_ack        : memory read completes this cycle
//   i_invalidate     : one-cycle pulse, invalidate the whole cache
// -----------------------------------------------------------------------------
module icache_controller
    import icache_controller_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    icache_controller_if.slave    cacheBus,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    input  inst_t                 i_mem_rdata,
    input  logic                  i_mem_ack,
    input  logic                  i_invalidate
);

    state_t    state_q, state_d;
    word_sel_t cnt_q;
    logic      inv_pending_q;
    tag_t      cap_tag_q;
    index_t    cap_index_q;
    line_t     line_buf_q;

    tag_t      req_tag;
    index_t    req_index;
    logic      unused_offset;

    logic      rd_valid;
    tag_t      rd_tag;
    line_t     rd_line;
    logic      hit;

    logic      busy;
    logic      start_fill;
    logic      word_done;
    logic      last_word;
    logic      install;
    logic      set_valid;
    logic      inv_all;

    assign req_tag       = cacheBus.addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_index     = cacheBus.addr[OFFSET_BITS +: INDEX_BITS];
    assign unused_offset = ^cacheBus.addr[OFFSET_BITS-1:0];

    icache_controller_storage u_storage (
        .clk       (i_clock),
        .rst_n     (i_reset),
        .rd_index  (req_index),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (install),
        .wr_index  (cap_index_q),
        .wr_tag    (cap_tag_q),
        .wr_line   (line_buf_q),
        .set_valid (set_valid),
        .inv_all   (inv_all)
    );

    assign hit = rd_valid && (rd_tag == req_tag);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        start_fill = 1'b0;
        word_done  = 1'b0;
        last_word  = 1'b0;
        install    = 1'b0;
        set_valid  = 1'b0;
        inv_all    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Lookup sees the valid bits from before a same-cycle invalidate.
                busy       = cacheBus.re && !hit;
                start_fill = cacheBus.re && !hit;
                inv_all    = i_invalidate;
                if (start_fill) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (i_mem_ack) begin
                    word_done = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        last_word = 1'b1;
                        state_d   = UPDATE;
                    end
                end
            end
            UPDATE: begin
                // An invalidate seen during the fill still installs the data,
                // but leaves the whole cache (this line included) invalid.
                install   = 1'b1;
                inv_all   = inv_pending_q || i_invalidate;
                set_valid = !(inv_pending_q || i_invalidate);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q         <= '0;
            o_mem_re      <= 1'b0;
            o_mem_addr    <= '0;
            inv_pending_q <= 1'b0;
        end else begin
            if (start_fill) begin
                cnt_q         <= '0;
                o_mem_re      <= 1'b1;
                o_mem_addr    <= word_addr(req_tag, req_index, '0);
                inv_pending_q <= 1'b0;
            end
            if (state_q == FILL && i_invalidate) begin
                inv_pending_q <= 1'b1;
            end
            if (word_done) begin
                if (last_word) begin
                    cnt_q    <= '0;
                    o_mem_re <= 1'b0;
                end else begin
                    // Request stays up, so the next word can be acked at once.
                    cnt_q      <= cnt_q + 1'b1;
                    o_mem_addr <= word_addr(cap_tag_q, cap_index_q, word_sel_t'(cnt_q + 1'b1));
                end
            end
            if (install) begin
                inv_pending_q <= 1'b0;
            end
        end
    end

    // Captured address and line buffer are fully rewritten by every fill.
    always_ff @(posedge i_clock) begin
        if (start_fill) begin
            cap_tag_q   <= req_tag;
            cap_index_q <= req_index;
        end
        if (word_done) begin
            line_buf_q[cnt_q] <= i_mem_rdata;
        end
    end

    assign cacheBus.busy = busy;
    assign cacheBus.inst = rd_line;

endmodule

// File: tb/tb_icache_controller.sv
// -----------------------------------------------------------------------------
// tb_icache_controller
// Self-checking bench: a line-level cache model (valid/tag/data per set plus
// the line being fetched) predicts busy, inst, o_mem_re and o_mem_addr every
// cycle; directed scenarios pin the model with literal expectations, then a
// randomized phase mixes addresses, ack delays, stray acks and invalidates.
// -----------------------------------------------------------------------------
module tb_icache_controller;
    import icache_controller_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] o_mem_addr;
    logic        o_mem_re;
    logic [31:0] i_mem_rdata = '0;
    logic        i_mem_ack = 1'b0;
    logic        i_invalidate = 1'b0;

    icache_controller_if bus ();

    icache_controller dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .cacheBus     (bus),
        .o_mem_addr   (o_mem_addr),
        .o_mem_re     (o_mem_re),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ack    (i_mem_ack),
        .i_invalidate (i_invalidate)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = serving lookups, 1 = fetching words, 2 = installing fetched line
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16][4];
    logic [31:0] m_buf   [4];
    int          m_phase = 0;
    logic [31:0] m_base  = '0;
    int          m_cnt   = 0;
    bit          m_pend  = 0;

    int          ack_delay = 1;
    int          ack_wait  = 0;
    bit          stray_en  = 0;

    int          busy_cycles;
    logic [31:0] acked_addrs [$];
    logic [127:0] last_inst;

    function automatic int index_of(logic [31:0] a);
        return int'((a >> 4) & 32'hF);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] a);
        return a >> 8;
    endfunction

    // Instruction memory contents; line 0x100 holds 0x11,0x22,0x33,0x44.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        if ((a >> 4) == 32'h10) return 32'h11 * (((a >> 2) & 32'h3) + 1);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) m_valid[s] = 0;
        m_phase = 0;
        m_cnt   = 0;
        m_pend  = 0;
    endtask

    task automatic cycle(input bit re, input logic [31:0] addr, input bit inv);
        bit           ack;
        bit           hit;
        logic [31:0]  rdata;
        logic [127:0] exp_line;
        int           idx;
        @(negedge i_clock);
        ack   = 0;
        rdata = $urandom;
        if (m_phase == 1) begin
            if (ack_wait >= ack_delay) begin
                ack      = 1;
                rdata    = mem_word(m_base + 32'(4 * m_cnt));
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end else if (stray_en && $urandom_range(3) == 0) begin
            ack = 1;
        end
        bus.re       = re;
        bus.addr     = addr;
        i_invalidate = inv;
        i_mem_ack    = ack;
        i_mem_rdata  = rdata;
        #1;
        idx = index_of(addr);
        hit = (m_phase == 0) && m_valid[idx] && (m_tag[idx] == tag_of(addr));
        check("busy", 128'(bus.busy), 128'(!(m_phase == 0 && (!re || hit))));
        check("mem_re", 128'(o_mem_re), 128'(m_phase == 1));
        if (m_phase == 1) check("mem_addr", 128'(o_mem_addr), 128'(m_base + 32'(4 * m_cnt)));
        if (re && hit) begin
            for (int w = 0; w < 4; w++) exp_line[32*w +: 32] = m_data[idx][w];
            check("inst", bus.inst, exp_line);
        end
        if (bus.busy) busy_cycles++;
        if (ack && m_phase == 1) acked_addrs.push_back(o_mem_addr);
        if (!bus.busy && re) last_inst = bus.inst;
        // what the next rising edge does
        case (m_phase)
            0: begin
                if (re && !hit) begin
                    m_phase  = 1;
                    m_base   = addr & ~32'hF;
                    m_cnt    = 0;
                    m_pend   = 0;
                    ack_wait = 0;
                end
                if (inv) for (int s = 0; s < 16; s++) m_valid[s] = 0;
            end
            1: begin
                if (inv) m_pend = 1;
                if (ack) begin
                    m_buf[m_cnt] = rdata;
                    m_cnt++;
                    if (m_cnt == 4) m_phase = 2;
                end
            end
            default: begin
                idx = index_of(m_base);
                m_tag[idx] = tag_of(m_base);
                for (int w = 0; w < 4; w++) m_data[idx][w] = m_buf[w];
                if (m_pend || inv) for (int s = 0; s < 16; s++) m_valid[s] = 0;
                else m_valid[idx] = 1;
                m_pend  = 0;
                m_phase = 0;
            end
        endcase
    endtask

    // Holds re on addr until the cache answers without busy.
    task automatic request(input logic [31:0] addr, input int inv_word, output int busy_n);
        bit done = 0;
        bit inv_sent = 0;
        bit inv;
        busy_cycles = 0;
        acked_addrs.delete();
        for (int c = 0; c < 200 && !done; c++) begin
            inv = (inv_word >= 0) && !inv_sent && m_phase == 1 && m_cnt == inv_word;
            if (inv) inv_sent = 1;
            cycle(1'b1, addr, inv);
            if (!bus.busy) done = 1;
        end
        check("request_done", 128'(done), 128'(1));
        busy_n = busy_cycles;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bn;
        bus.re   = 1'b0;
        bus.addr = '0;
        model_reset();

        // reset state
        #1;
        check("rst_mem_re", 128'(o_mem_re), 128'(0));
        check("rst_mem_addr", 128'(o_mem_addr), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        idle(2);

        // cold miss on 0x100, one wait state per word
        ack_delay = 1;
        request(32'h100, -1, bn);
        check("s1_busy_cycles", 128'(bn), 128'(10));
        check("s1_acks", 128'(acked_addrs.size()), 128'(4));
        if (acked_addrs.size() == 4) begin
            check("s1_addr0", 128'(acked_addrs[0]), 128'(32'h100));
            check("s1_addr1", 128'(acked_addrs[1]), 128'(32'h104));
            check("s1_addr2", 128'(acked_addrs[2]), 128'(32'h108));
            check("s1_addr3", 128'(acked_addrs[3]), 128'(32'h10C));
        end
        check("s1_inst", last_inst, 128'h00000044_00000033_00000022_00000011);

        // hit on the same line, zero latency
        cycle(1'b1, 32'h108, 1'b0);
        check("s2_busy", 128'(bus.busy), 128'(0));
        check("s2_mem_re", 128'(o_mem_re), 128'(0));
        check("s2_inst", bus.inst, 128'h00000044_00000033_00000022_00000011);

        // conflict on set 0
        request(32'h500, -1, bn);
        check("s3_busy_500", 128'(bn), 128'(10));
        check("s3_first_addr", 128'(acked_addrs.size() > 0 ? acked_addrs[0] : 32'hX), 128'(32'h500));
        request(32'h100, -1, bn);
        check("s3_busy_100", 128'(bn), 128'(10));

        // back-to-back acks
        ack_delay = 0;
        request(32'h300, -1, bn);
        check("s4_busy_cycles", 128'(bn), 128'(6));
        cycle(1'b1, 32'h304, 1'b0);
        check("s4_hit", 128'(bus.busy), 128'(0));

        // invalidate during the second word: fill, miss again, refill
        ack_delay = 1;
        request(32'h200, 1, bn);
        check("s5_busy_refetch", 128'(bn), 128'(20));
        check("s5_acks", 128'(acked_addrs.size()), 128'(8));
        request(32'h100, -1, bn);
        check("s5_busy_100", 128'(bn), 128'(10));

        // asynchronous reset after two words of a fill
        for (int c = 0; c < 20 && !(m_phase == 1 && m_cnt == 2); c++) cycle(1'b1, 32'h400, 1'b0);
        check("s6_reached_word2", 128'(m_cnt), 128'(2));
        #2;
        i_reset   = 1'b0;
        bus.re    = 1'b0;
        i_mem_ack = 1'b1;
        #1;
        check("s6_mem_re_async", 128'(o_mem_re), 128'(0));
        check("s6_busy_async", 128'(bus.busy), 128'(0));
        model_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        request(32'h400, -1, bn);
        check("s6_busy_restart", 128'(bn), 128'(10));
        check("s6_restart_addr", 128'(acked_addrs.size() > 0 ? acked_addrs[0] : 32'hX), 128'(32'h400));

        // randomized traffic against the model
        stray_en = 1;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a;
            if (c % 50 == 0) ack_delay = int'($urandom_range(2));
            a = (32'($urandom_range(2)) << 8) | (32'($urandom_range(3)) << 4) | 32'($urandom_range(15));
            cycle(1'($urandom_range(3) != 0), a, 1'($urandom_range(40) == 0));
        end
        stray_en = 0;
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
